// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types, extended with the memory-arbiter state encoding.
package lc3b_types;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_c_block;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } arb_state_t;

endpackage

// File: rtl/cache_arbiter_rr_pick.sv
// Rotating first-one search: lowest pending index at or after ptr, modulo N.
module rr_pick #(
   parameter  int unsigned N  = 2,
   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  pending,
   input  logic [PW-1:0] ptr,
   output logic          valid,
   output logic [PW-1:0] idx
);

   logic [PW-1:0] cand;

   always_comb begin
      valid = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = PW'((32'(ptr) + k) % N);
         if (!valid && pending[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/register.sv
// Generic load-enabled register with asynchronous active-high clear.
module register #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o
);

   logic [WIDTH-1:0] data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         data_q <= '0;
      else if (load_i)
         data_q <= data_i;
   end

   assign data_o = data_q;

endmodule

// File: rtl/cache_arbiter_rr.sv
// Round-robin N-port arbiter funnelling L1 miss traffic onto one L2 port;
// captures address/wdata at grant and returns a registered read line.
module cache_arbiter_rr
   import lc3b_types::*;
#(
   parameter int unsigned NUM_PORTS  = 2,
   parameter int unsigned ADDR_WIDTH = $bits(lc3b_word),
   parameter int unsigned DATA_WIDTH = $bits(lc3b_c_block)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_PORTS-1:0]            req_read,
   input  logic [NUM_PORTS-1:0]            req_write,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_PORTS-1:0]            req_resp,
   output logic [DATA_WIDTH-1:0]           req_rdata,
   output logic                            l2_read,
   output logic                            l2_write,
   output logic [ADDR_WIDTH-1:0]           l2_address,
   output logic [DATA_WIDTH-1:0]           l2_wdata,
   input  logic [DATA_WIDTH-1:0]           l2_rdata,
   input  logic                            l2_resp
);

   localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   arb_state_t           state_q;
   logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]        grant_q;
   logic                 l2_read_q, l2_write_q;
   logic [NUM_PORTS-1:0] req_resp_q;

   logic [NUM_PORTS-1:0]  pending;
   logic                  pick_valid;
   logic [PW-1:0]         pick_idx;
   logic [ADDR_WIDTH-1:0] addr_sel;
   logic [DATA_WIDTH-1:0] wdata_sel;
   logic                  capture;
   logic                  rdata_ld;

   assign pending = req_read | req_write;

   rr_pick #(
      .N(NUM_PORTS)
   ) u_pick (
      .pending(pending),
      .ptr    (rr_ptr_q),
      .valid  (pick_valid),
      .idx    (pick_idx)
   );

   always_comb begin
      addr_sel  = '0;
      wdata_sel = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (pick_idx == PW'(i)) begin
            addr_sel  = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_sel = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign capture  = (state_q == IDLE) && pick_valid;
   assign rdata_ld = (state_q == BUSY) && l2_resp;
   assign rr_ptr_d = (grant_q == PW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;

   // Write wins when a port raises both strobes; l2_write_q doubles as the captured op.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         l2_read_q  <= 1'b0;
         l2_write_q <= 1'b0;
         req_resp_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               req_resp_q <= '0;
               if (pick_valid) begin
                  grant_q    <= pick_idx;
                  l2_write_q <= req_write[pick_idx];
                  l2_read_q  <= ~req_write[pick_idx];
                  state_q    <= BUSY;
               end
            end
            BUSY: begin
               if (l2_resp) begin
                  l2_read_q  <= 1'b0;
                  l2_write_q <= 1'b0;
                  req_resp_q <= NUM_PORTS'(1) << grant_q;
                  state_q    <= RESP;
               end
            end
            RESP: begin
               req_resp_q <= '0;
               rr_ptr_q   <= rr_ptr_d;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   register #(.WIDTH(ADDR_WIDTH)) u_addr_reg (
      .clk(clk), .rst(rst), .load_i(capture), .data_i(addr_sel), .data_o(l2_address)
   );

   register #(.WIDTH(DATA_WIDTH)) u_wdata_reg (
      .clk(clk), .rst(rst), .load_i(capture), .data_i(wdata_sel), .data_o(l2_wdata)
   );

   register #(.WIDTH(DATA_WIDTH)) u_rdata_reg (
      .clk(clk), .rst(rst), .load_i(rdata_ld), .data_i(l2_rdata), .data_o(req_rdata)
   );

   assign l2_read  = l2_read_q;
   assign l2_write = l2_write_q;
   assign req_resp = req_resp_q;

endmodule

// File: tb/tb_cache_arbiter_rr.sv
// Directed and randomized checks of cache_arbiter_rr against a transaction-level model.
module tb_cache_arbiter_rr;

   localparam int NP = 4;
   localparam int AW = 16;
   localparam int DW = 128;

   logic             clk = 1'b0;
   logic             rst;
   logic [NP-1:0]    req_read, req_write, req_resp;
   logic [NP*AW-1:0] req_address;
   logic [NP*DW-1:0] req_wdata;
   logic [DW-1:0]    req_rdata, l2_wdata, l2_rdata;
   logic             l2_read, l2_write, l2_resp;
   logic [AW-1:0]    l2_address;

   int errors = 0;
   int checks = 0;

   cache_arbiter_rr #(
      .NUM_PORTS (NP),
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW)
   ) dut (
      .clk(clk), .rst(rst),
      .req_read(req_read), .req_write(req_write),
      .req_address(req_address), .req_wdata(req_wdata),
      .req_resp(req_resp), .req_rdata(req_rdata),
      .l2_read(l2_read), .l2_write(l2_write),
      .l2_address(l2_address), .l2_wdata(l2_wdata),
      .l2_rdata(l2_rdata), .l2_resp(l2_resp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int i, input logic r, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_read[i]              = r;
      req_write[i]             = w;
      req_address[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW]    = d;
   endtask

   task automatic do_reset();
      req_read  = '0;
      req_write = '0;
      l2_resp   = 1'b0;
      l2_rdata  = '0;
      rst       = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   function automatic logic [NP-1:0] onehot(input int p);
      logic [NP-1:0] v;
      v    = '0;
      v[p] = 1'b1;
      return v;
   endfunction

   // random-phase model state
   int               mptr, cur, delay, age, done;
   bit               active, resp_due, found;
   logic [DW-1:0]    ret;
   logic [NP-1:0]    snap_r, snap_w;
   logic [NP*AW-1:0] snap_a;
   logic [NP*DW-1:0] snap_d;
   int               npulse, last_pulse;
   logic [DW-1:0]    tmp;

   initial begin
      req_address = '0;
      req_wdata   = '0;

      // reset values
      do_reset();
      rst = 1'b1;
      #1;
      chk("rst_req_resp", req_resp, '0);
      chk("rst_req_rdata", req_rdata, '0);
      chk("rst_l2_read", l2_read, '0);
      chk("rst_l2_write", l2_write, '0);
      chk("rst_l2_address", l2_address, '0);
      chk("rst_l2_wdata", l2_wdata, '0);
      rst = 1'b0;

      // single icache read with 3-cycle L2 latency
      set_port(0, 1'b1, 1'b0, 16'h1230, '0);
      step();
      chk("rd_l2_read_c1", l2_read, 1);
      chk("rd_l2_write_c1", l2_write, 0);
      chk("rd_l2_address", l2_address, 16'h1230);
      step();
      chk("rd_l2_read_c2", l2_read, 1);
      step();
      chk("rd_l2_read_c3", l2_read, 1);
      l2_resp  = 1'b1;
      l2_rdata = {16{8'hA5}};
      step();
      chk("rd_req_resp", req_resp, 4'b0001);
      chk("rd_req_rdata", req_rdata, {16{8'hA5}});
      chk("rd_l2_read_done", l2_read, 0);
      l2_resp  = 1'b0;
      l2_rdata = '0;
      req_read = '0;
      step();
      chk("rd_req_resp_pulse", req_resp, 4'b0000);

      // icache read + dcache write together, then dcache drops mid-BUSY
      do_reset();
      set_port(0, 1'b1, 1'b0, 16'h1111, '0);
      set_port(1, 1'b0, 1'b1, 16'h4000, {8{16'hDEAD}});
      step();
      chk("mix_first_read", l2_read, 1);
      chk("mix_first_write", l2_write, 0);
      chk("mix_first_addr", l2_address, 16'h1111);
      l2_resp  = 1'b1;
      l2_rdata = {16{8'h77}};
      step();
      chk("mix_resp0", req_resp, 4'b0001);
      l2_resp     = 1'b0;
      req_read[0] = 1'b0;
      step();
      chk("mix_idle_gap", {l2_read, l2_write}, 2'b00);
      chk("mix_idle_resp", req_resp, 4'b0000);
      step();
      chk("mix_write", l2_write, 1);
      chk("mix_write_rd", l2_read, 0);
      chk("mix_write_addr", l2_address, 16'h4000);
      chk("mix_write_data", l2_wdata, {8{16'hDEAD}});
      req_write[1] = 1'b0;
      step();
      chk("drop_write_held", l2_write, 1);
      chk("drop_addr_held", l2_address, 16'h4000);
      l2_resp = 1'b1;
      step();
      chk("drop_resp1", req_resp, 4'b0010);
      chk("drop_write_low", l2_write, 0);
      l2_resp = 1'b0;
      step();
      step();
      chk("drop_no_regrant", {l2_read, l2_write}, 2'b00);
      chk("drop_no_resp", req_resp, 4'b0000);
      chk("addr_holds_idle", l2_address, 16'h4000);

      // asynchronous reset in the middle of a transaction
      do_reset();
      set_port(2, 1'b0, 1'b1, 16'h2222, {4{32'hCAFEF00D}});
      step();
      chk("arst_busy", l2_write, 1);
      chk("arst_busy_addr", l2_address, 16'h2222);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_l2_read", l2_read, 0);
      chk("arst_l2_write", l2_write, 0);
      chk("arst_l2_address", l2_address, '0);
      chk("arst_l2_wdata", l2_wdata, '0);
      chk("arst_req_resp", req_resp, '0);
      set_port(0, 1'b1, 1'b0, 16'h0A0A, '0);
      step();
      rst = 1'b0;
      step();
      chk("arst_regrant_port0", l2_read, 1);
      chk("arst_regrant_addr", l2_address, 16'h0A0A);
      l2_resp = 1'b1;
      step();
      chk("arst_regrant_resp", req_resp, 4'b0001);

      // stray l2_resp while idle
      do_reset();
      l2_resp  = 1'b1;
      l2_rdata = {8{16'h5555}};
      step();
      chk("stray_no_resp", req_resp, 4'b0000);
      chk("stray_no_capture", req_rdata, '0);
      chk("stray_no_strobe", {l2_read, l2_write}, 2'b00);
      l2_resp = 1'b0;
      set_port(3, 1'b1, 1'b0, 16'h3333, '0);
      step();
      chk("stray_grant3", l2_read, 1);
      chk("stray_grant3_addr", l2_address, 16'h3333);
      l2_resp  = 1'b1;
      l2_rdata = {8{16'h9999}};
      step();
      chk("stray_resp3", req_resp, 4'b1000);
      chk("stray_rdata3", req_rdata, {8{16'h9999}});

      // fairness: all ports requesting continuously, L2 answering every cycle
      do_reset();
      for (int i = 0; i < NP; i++)
         set_port(i, 1'b1, 1'b0, AW'(16'h0100 * (i + 1)), '0);
      l2_resp    = 1'b1;
      npulse     = 0;
      last_pulse = -1;
      for (int c = 1; c <= 18; c++) begin
         step();
         if (req_resp !== '0) begin
            chk("fair_order", req_resp, onehot(npulse % NP));
            if (last_pulse >= 0)
               chk("fair_spacing", c - last_pulse, 3);
            last_pulse = c;
            npulse++;
         end
      end
      chk("fair_pulse_count", npulse, 6);

      // randomized traffic against the transaction-level model
      do_reset();
      mptr     = 0;
      active   = 0;
      resp_due = 0;
      done     = 0;
      age      = 0;
      cur      = 0;
      delay    = 0;
      ret      = '0;
      for (int c = 0; c < 600; c++) begin
         snap_r = req_read;
         snap_w = req_write;
         snap_a = req_address;
         snap_d = req_wdata;
         step();
         if (resp_due) begin
            chk("rand_resp", req_resp, onehot(cur));
            chk("rand_rdata", req_rdata, ret);
            chk("rand_strobe_off", {l2_read, l2_write}, 2'b00);
            req_read[cur]  = 1'b0;
            req_write[cur] = 1'b0;
            l2_resp  = 1'b0;
            resp_due = 0;
            active   = 0;
            mptr     = (cur + 1) % NP;
            done++;
         end else if (req_resp !== '0) begin
            chk("rand_spurious_resp", req_resp, '0);
         end
         if (!active && (l2_read || l2_write)) begin
            found = 0;
            for (int k = 0; k < NP; k++) begin
               if (!found && (snap_r[(mptr + k) % NP] || snap_w[(mptr + k) % NP])) begin
                  found = 1;
                  cur   = (mptr + k) % NP;
               end
            end
            chk("rand_pick_valid", found, 1);
            chk("rand_op_write", l2_write, snap_w[cur]);
            chk("rand_op_read", l2_read, !snap_w[cur]);
            chk("rand_addr", l2_address, snap_a[cur*AW +: AW]);
            if (snap_w[cur])
               chk("rand_wdata", l2_wdata, snap_d[cur*DW +: DW]);
            active = 1;
            age    = 0;
            delay  = $urandom_range(0, 3);
         end else if (active && !resp_due) begin
            chk("rand_strobe_held", l2_read || l2_write, 1);
         end
         if (active && !resp_due) begin
            age++;
            if (age > 10) begin
               chk("rand_timeout", 0, 1);
               active = 0;
            end else if (delay == 0) begin
               tmp      = {$urandom, $urandom, $urandom, $urandom};
               ret      = tmp;
               l2_rdata = tmp;
               l2_resp  = 1'b1;
               resp_due = 1;
            end else begin
               delay--;
            end
         end
         for (int i = 0; i < NP; i++) begin
            if (!req_read[i] && !req_write[i] && !(resp_due == 0 && done > 0 && i == cur && req_resp != '0)
                && $urandom_range(0, 2) == 0) begin
               case ($urandom_range(0, 9))
                  0:       set_port(i, 1'b1, 1'b1, AW'($urandom), {$urandom, $urandom, $urandom, $urandom});
                  1, 2, 3: set_port(i, 1'b0, 1'b1, AW'($urandom), {$urandom, $urandom, $urandom, $urandom});
                  default: set_port(i, 1'b1, 1'b0, AW'($urandom), {$urandom, $urandom, $urandom, $urandom});
               endcase
            end
         end
      end
      chk("rand_txn_count", done >= 30, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
